c_result_streamer: RTL and testbench

- Downstream stage of the systolic matrix-multiply top level; consumes its `done` flag and flattened result bus `C_flat`.
- On each rising edge of `done`, snapshots the N*N result matrix into an internal register bank.
- Streams the snapshot out one element per beat, row-major, over a valid/ready interface with a write address. Suitable for a result BRAM write port or a host readout path.
- Frees the array to start the next multiply while results drain.

---
 rtl/c_result_streamer.sv | 119 +++++++++++
 tb/tb_c_result_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/c_result_streamer.sv
// Snapshots the systolic array's N*N result on each done rising edge and streams it row-major
// over valid/ready with a write address. Define C_RESULT_STREAMER_CHECKSUM_EN to add `checksum`.
module c_result_streamer #(
  parameter int unsigned N         = 4,
  parameter int unsigned ACCW      = 16,
  parameter int unsigned ADDRW     = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_in,
  input  logic [ACCW*N*N-1:0]     c_flat,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ACCW-1:0]         m_data,
  output logic [ADDRW-1:0]        m_addr,
  output logic                    m_last,
  output logic                    busy,
  output logic                    wr_done,
`ifdef C_RESULT_STREAMER_CHECKSUM_EN
  output logic [ACCW+$clog2(N*N)-1:0] checksum,
`endif
  output logic                    overrun
);

  localparam int unsigned Elems = N * N;
  localparam int unsigned IdxW  = (Elems > 1) ? $clog2(Elems) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Elems - 1);
  localparam logic [ADDRW-1:0] BaseAddr = ADDRW'(BASE_ADDR);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_done_q;
  logic [ACCW*Elems-1:0] r_snap;
  logic [IdxW-1:0]       r_idx, w_idx_nxt;
  logic                  r_wr_done, w_wr_done_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic                  w_cap, w_capture, w_xfer, w_at_last;

  assign w_cap     = done_in & ~r_done_q;
  assign w_at_last = (r_idx == LastIdx);
  assign w_xfer    = m_valid & m_ready;

  // A cap seen on the final-beat cycle is still in StStream, so it counts as overrun.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wr_done_nxt = 1'b0;
    w_overrun_nxt = r_overrun;
    w_capture     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cap) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = StStream;
        end
      end
      StStream: begin
        if (w_cap) w_overrun_nxt = 1'b1;
        if (w_xfer) begin
          if (w_at_last) begin
            w_idx_nxt     = '0;
            w_state_nxt   = StIdle;
            w_wr_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_done_q  <= 1'b0;
      r_idx     <= '0;
      r_wr_done <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done_q  <= done_in;
      r_idx     <= w_idx_nxt;
      r_wr_done <= w_wr_done_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_snap <= c_flat;
  end

  assign m_valid = (r_state == StStream);
  assign busy    = m_valid;
  assign m_last  = m_valid & w_at_last;
  assign m_data  = m_valid ? r_snap[r_idx*ACCW +: ACCW] : '0;
  assign m_addr  = BaseAddr + ADDRW'(r_idx);
  assign wr_done = r_wr_done;
  assign overrun = r_overrun;

`ifdef C_RESULT_STREAMER_CHECKSUM_EN
  localparam int unsigned CsW = ACCW + $clog2(Elems);

  logic [CsW-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset || w_capture) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + CsW'(m_data);
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_c_result_streamer.sv
// Scoreboard bench for c_result_streamer: a transaction-level model queues expected beats at
// each accepted capture; a negedge monitor compares every presented beat and the status flags.
module tb_c_result_streamer;
  localparam int N     = 4;
  localparam int ACCW  = 16;
  localparam int ADDRW = 9;
  localparam int BASE  = 508;
  localparam int E     = N * N;
  localparam int CSW   = ACCW + $clog2(E);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                done_in = 1'b0;
  logic                m_ready = 1'b0;
  logic [ACCW*E-1:0]   c_flat = '0;
  logic                m_valid, m_last, busy, wr_done, overrun;
  logic [ACCW-1:0]     m_data;
  logic [ADDRW-1:0]    m_addr;
`ifdef C_RESULT_STREAMER_CHECKSUM_EN
  logic [CSW-1:0]      checksum;
`endif

  c_result_streamer #(.N(N), .ACCW(ACCW), .ADDRW(ADDRW), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .done_in (done_in),
    .c_flat  (c_flat),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_addr  (m_addr),
    .m_last  (m_last),
    .busy    (busy),
    .wr_done (wr_done),
`ifdef C_RESULT_STREAMER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACCW-1:0]  d;
    logic [ADDRW-1:0] a;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture is accepted only when no result is outstanding; each ready
  // cycle while outstanding consumes one element, and the 16th consumption ends the result.
  bit             mdl_busy = 0, mdl_wrd = 0, mdl_ovr = 0, mdl_prev = 0;
  int             mdl_beat = 0;
  logic [ACCW-1:0] mdl_snap[E];
  logic [CSW-1:0] mdl_sum = '0;

  always @(posedge clk) begin : model
    bit    cap;
    beat_t b;
    if (reset) begin
      mdl_busy = 0; mdl_wrd = 0; mdl_ovr = 0; mdl_prev = 0; mdl_beat = 0; mdl_sum = '0;
      exp_q.delete();
    end else begin
      cap      = done_in && !mdl_prev;
      mdl_prev = done_in;
      mdl_wrd  = 0;
      if (mdl_busy) begin
        if (cap) mdl_ovr = 1;
        if (m_ready) begin
          mdl_sum = mdl_sum + CSW'(mdl_snap[mdl_beat]);
          mdl_beat++;
          if (mdl_beat == E) begin
            mdl_busy = 0;
            mdl_wrd  = 1;
          end
        end
      end else if (cap) begin
        mdl_busy = 1;
        mdl_beat = 0;
        mdl_sum  = '0;
        for (int i = 0; i < E; i++) begin
          mdl_snap[i] = c_flat[i*ACCW +: ACCW];
          b.d = mdl_snap[i];
          b.a = ADDRW'((BASE + i) % (1 << ADDRW));
          b.l = (i == E - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    chk("valid", 32'(m_valid), 32'(mdl_busy));
    chk("busy", 32'(busy), 32'(mdl_busy));
    chk("wr_done", 32'(wr_done), 32'(mdl_wrd));
    chk("overrun", 32'(overrun), 32'(mdl_ovr));
`ifdef C_RESULT_STREAMER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(mdl_sum));
`endif
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(m_valid), 32'd0);
      end else begin
        chk("data", 32'(m_data), 32'(exp_q[0].d));
        chk("addr", 32'(m_addr), 32'(exp_q[0].a));
        chk("last", 32'(m_last), 32'(exp_q[0].l));
        if (m_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("last_idle", 32'(m_last), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    step(1);
    done_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step(2);
    chk("rst_addr", 32'(m_addr), 32'(BASE));
    chk("rst_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    step(1);

    // Basic stream, element idx = 3*idx+1, constant ready.
    for (int i = 0; i < E; i++) c_flat[i*ACCW +: ACCW] = ACCW'(3 * i + 1);
    m_ready = 1'b1;
    pulse_done();
    step(20);

    // Backpressure with ready pattern 1,0,0,1.
    pulse_done();
    for (int c = 0; c < 70; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      step(1);
    end

    // Held done gives one stream; a second edge mid-stream sets sticky overrun.
    m_ready = 1'b1;
    done_in = 1'b1;
    step(40);
    done_in = 1'b0;
    step(5);
    pulse_done();
    step(6);
    pulse_done();
    step(20);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-stream, then a fresh capture restarts from element 0.
    pulse_done();
    step(5);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < E; i++) c_flat[i*ACCW +: ACCW] = ACCW'($urandom);
    pulse_done();
    step(20);

    // Second edge around the final beat: overrun vs accepted back-to-back capture.
    for (int gap = 14; gap <= 18; gap++) begin
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(1);
      pulse_done();
      step(gap - 1);
      for (int i = 0; i < E; i++) c_flat[i*ACCW +: ACCW] = ACCW'($urandom);
      pulse_done();
      step(40);
    end

`ifdef C_RESULT_STREAMER_CHECKSUM_EN
    begin : cs_test
      bit seen;
      seen = 0;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < E; i++) c_flat[i*ACCW +: ACCW] = '1;
      pulse_done();
      for (int c = 0; c < 40 && !seen; c++) begin
        step(1);
        if (wr_done) seen = 1;
      end
      chk("checksum_wr_done_seen", 32'(seen), 32'd1);
      chk("checksum_final", 32'(checksum), 32'd1048560);
      pulse_done();
      chk("checksum_clear", 32'(checksum), 32'd0);
      step(20);
    end
`endif

    // Randomised traffic, including rare resets.
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 149) == 0);
      done_in = ($urandom_range(0, 3) == 0);
      m_ready = $urandom_range(0, 1);
      for (int i = 0; i < E; i++) c_flat[i*ACCW +: ACCW] = ACCW'($urandom);
      step(1);
    end

    reset   = 1'b0;
    done_in = 1'b0;
    m_ready = 1'b1;
    step(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
